// File: rtl/rb_dump_ctrl_pkg.sv
// rtl/rb_dump_ctrl_pkg.sv - shared defaults, FSM states and helpers for rb_dump_ctrl (RB_DUMP_CHECKSUM_EN adds CHKSUM)
package rb_dump_ctrl_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_REG_DEF  = 5;
    localparam int N_REGS_DEF  = 32;
    localparam int NB_BYTE_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_SEND,
`ifdef RB_DUMP_CHECKSUM_EN
        ST_CHKSUM,
`endif
        ST_DONE
    } state_t;

    // Index counters need at least one bit even for a single-byte word.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rb_dump_ctrl_word_serializer.sv
// rtl/rb_dump_ctrl_word_serializer.sv - loads one word and hands it out MSB-first, one byte per valid/ready transfer
module rb_dump_ctrl_word_serializer
    import rb_dump_ctrl_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_BYTE = NB_BYTE_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_tx_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_last
);

    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int NB_IDX = idx_width(BYTES_PER_WORD);
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(BYTES_PER_WORD - 1);

    logic [NB_DATA-1:0] shift;
    logic [NB_IDX-1:0]  idx;
    logic               valid;
    logic               xfer;

    assign o_tx_data  = shift[NB_DATA-1 -: NB_BYTE];
    assign o_tx_valid = valid;
    assign xfer       = valid & i_tx_ready;
    assign o_last     = xfer && (idx == LAST_IDX);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            shift <= '0;
            idx   <= '0;
            valid <= 1'b0;
        end else if (i_load) begin
            shift <= i_data;
            idx   <= '0;
            valid <= 1'b1;
        end else if (xfer) begin
            shift <= shift << NB_BYTE;
            idx   <= idx + 1'b1;
            if (idx == LAST_IDX) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rb_dump_ctrl.sv
// rtl/rb_dump_ctrl.sv - register bank dump FSM: read, capture, byte-stream each word (RB_DUMP_CHECKSUM_EN appends XOR byte)
module rb_dump_ctrl
    import rb_dump_ctrl_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_REG  = NB_REG_DEF,
    parameter int N_REGS  = N_REGS_DEF,
    parameter int NB_BYTE = NB_BYTE_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_rb_data,
    input  logic               i_tx_ready,
    output logic               o_rb_read_enable,
    output logic [NB_REG-1:0]  o_rb_read_addr,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [NB_REG-1:0] LAST_REG = NB_REG'(N_REGS - 1);

    state_t             state;
    logic [NB_REG-1:0]  counter;
    logic               ser_load;
    logic               ser_last;
    logic               ser_valid;
    logic [NB_BYTE-1:0] ser_data;

    assign ser_load       = (state == ST_CAPTURE);
    assign o_rb_read_addr = counter;

    rb_dump_ctrl_word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (ser_load),
        .i_data     (i_rb_data),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (ser_data),
        .o_tx_valid (ser_valid),
        .o_last     (ser_last)
    );

`ifdef RB_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] checksum;
    logic               chk_valid;

    assign o_tx_data  = chk_valid ? checksum : ser_data;
    assign o_tx_valid = ser_valid | chk_valid;
`else
    assign o_tx_data  = ser_data;
    assign o_tx_valid = ser_valid;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state            <= ST_IDLE;
            counter          <= '0;
            o_rb_read_enable <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
`ifdef RB_DUMP_CHECKSUM_EN
            checksum         <= '0;
            chk_valid        <= 1'b0;
`endif
        end else begin
            o_rb_read_enable <= 1'b0;
            o_done           <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state            <= ST_READ;
                        counter          <= '0;
                        o_rb_read_enable <= 1'b1;
                        o_busy           <= 1'b1;
`ifdef RB_DUMP_CHECKSUM_EN
                        checksum         <= '0;
`endif
                    end
                end
                ST_READ:    state <= ST_CAPTURE;
                ST_CAPTURE: state <= ST_SEND;
                ST_SEND: begin
`ifdef RB_DUMP_CHECKSUM_EN
                    if (ser_valid && i_tx_ready) begin
                        checksum <= checksum ^ ser_data;
                    end
`endif
                    if (ser_last) begin
                        if (counter == LAST_REG) begin
`ifdef RB_DUMP_CHECKSUM_EN
                            state     <= ST_CHKSUM;
                            chk_valid <= 1'b1;
`else
                            state  <= ST_DONE;
                            o_done <= 1'b1;
`endif
                        end else begin
                            counter          <= counter + 1'b1;
                            state            <= ST_READ;
                            o_rb_read_enable <= 1'b1;
                        end
                    end
                end
`ifdef RB_DUMP_CHECKSUM_EN
                ST_CHKSUM: begin
                    if (i_tx_ready) begin
                        chk_valid <= 1'b0;
                        state     <= ST_DONE;
                        o_done    <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rb_dump_ctrl.sv
// tb/tb_rb_dump_ctrl.sv - directed/random bench for rb_dump_ctrl against a byte-queue reference model
module tb_rb_dump_ctrl;

    localparam int N = 32;
`ifdef RB_DUMP_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn, start, tx_ready, s_start;
    logic [31:0] rb_data, s_rb_data;
    logic        rd_en, tx_valid, busy, done;
    logic [4:0]  rd_addr;
    logic [7:0]  tx_data;
    logic        s_rd_en, s_tx_valid, s_busy, s_done;
    logic [4:0]  s_rd_addr;
    logic [7:0]  s_tx_data;
    logic [31:0] mem [N];
    logic [31:0] s_mem0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    rb_dump_ctrl #(.NB_DATA(32), .NB_REG(5), .N_REGS(N), .NB_BYTE(8)) dut (
        .i_clock(clk), .i_reset(resetn), .i_start(start), .i_rb_data(rb_data),
        .i_tx_ready(tx_ready), .o_rb_read_enable(rd_en), .o_rb_read_addr(rd_addr),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .o_busy(busy), .o_done(done)
    );

    rb_dump_ctrl #(.NB_DATA(32), .NB_REG(5), .N_REGS(1), .NB_BYTE(8)) dut_small (
        .i_clock(clk), .i_reset(resetn), .i_start(s_start), .i_rb_data(s_rb_data),
        .i_tx_ready(tx_ready), .o_rb_read_enable(s_rd_en), .o_rb_read_addr(s_rd_addr),
        .o_tx_data(s_tx_data), .o_tx_valid(s_tx_valid), .o_busy(s_busy), .o_done(s_done)
    );

    // Register bank: synchronous read, data valid the cycle after the enable.
    always @(posedge clk) begin
        if (rd_en) rb_data <= mem[rd_addr];
        if (s_rd_en) s_rb_data <= s_mem0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_dump(input bit rand_ready, input int restart_reg, input int abort_byte);
        logic [7:0] exp_q[$];
        logic [7:0] x;
        logic [7:0] prev_data;
        int cyc, rd_cyc, val_cyc, done_cyc, dones, nbytes, exp_addr, exp_total;
        bit prev_stall, fire, aborted;
        x = '0; prev_data = '0;
        cyc = 0; rd_cyc = -1; val_cyc = -1; done_cyc = -1;
        dones = 0; nbytes = 0; exp_addr = 0;
        prev_stall = 0; fire = 0; aborted = 0;
        for (int i = 0; i < N; i++) begin
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(mem[i][31-8*b -: 8]);
                x ^= mem[i][31-8*b -: 8];
            end
        end
`ifdef RB_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        exp_total = exp_q.size();
        @(posedge clk); #1;
        start = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        while (cyc < 3000 && !aborted && !(done_cyc >= 0 && cyc >= done_cyc + 2)) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, prev_data);
            end
            if (rd_en) begin
                if (rd_cyc < 0) rd_cyc = cyc;
                check("rd_addr", rd_addr, exp_addr);
                if (int'(rd_addr) == restart_reg) fire = 1;
                exp_addr++;
            end
            if (tx_valid && val_cyc < 0) val_cyc = cyc;
            if (tx_valid && tx_ready) begin
                if (nbytes == abort_byte) begin
                    aborted = 1;
                    resetn = 1'b0;
                end else begin
                    if (exp_q.size() > 0) check("byte", tx_data, exp_q.pop_front());
                    nbytes++;
                end
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) check("busy_after_done", busy, 0);
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
            @(posedge clk); #1;
            start = fire;
            fire = 0;
            tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (abort_byte >= 0) begin
            check("abort_reached", aborted, 1);
            @(negedge clk);
            check("abort_outputs", {rd_en, rd_addr, tx_data, tx_valid, busy, done}, 0);
            @(posedge clk); #1;
            resetn = 1'b1;
        end else begin
            check("done_seen", done_cyc >= 0, 1);
            check("byte_count", nbytes, exp_total);
            check("done_pulses", dones, 1);
            check("first_valid_lat", val_cyc - rd_cyc, 2);
            if (!rand_ready) check("done_lat", done_cyc - rd_cyc, 6 * N + CHK);
            check("busy_idle", busy, 0);
        end
    endtask

    initial begin
        int sn, c, s_done_cyc;
        logic [31:0] sw;
        resetn = 1'b0; start = 1'b0; s_start = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 32'h0102_0300 + i;
        s_mem0 = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_main", {rd_en, rd_addr, tx_data, tx_valid, busy, done}, 0);
        check("reset_small", {s_rd_en, s_rd_addr, s_tx_data, s_tx_valid, s_busy, s_done}, 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        run_dump(0, -1, -1);
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        run_dump(1, -1, -1);
        run_dump(0, 5, -1);
        for (int i = 0; i < N; i++) mem[i] = 32'h0102_0300 + i;
        run_dump(0, -1, 10 * 4 + 2);
        run_dump(0, -1, -1);
        for (int i = 0; i < N; i++) mem[i] = 32'hFFFF_FFFF;
        run_dump(1, -1, -1);

        sn = 0; c = 0; s_done_cyc = -1; sw = '0;
        @(posedge clk); #1;
        s_start = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        while (c < 40 && s_done_cyc < 0) begin
            @(negedge clk);
            c++;
            if (s_rd_en) check("s_addr", s_rd_addr, 0);
            if (s_tx_valid && tx_ready) begin
                if (sn < 4) sw = {sw[23:0], s_tx_data};
                sn++;
            end
            if (s_done) s_done_cyc = c;
            @(posedge clk); #1;
        end
        check("s_done_seen", s_done_cyc >= 0, 1);
        check("s_word", sw, 32'hDEAD_BEEF);
        check("s_bytes", sn, 4 + CHK);
        @(negedge clk);
        check("s_busy_low", s_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
